// File: rtl/mac_neuron_pkg.sv
// Shared types, default widths and saturation bounds for the mac_neuron block.
package mac_neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ACC_W    = 32;
    localparam int DEF_N_INPUTS = 16;
    localparam int DEF_GUARD_W  = 8;

    // Bounds are computed at 64 bits; callers narrow them to their accumulator width.
    function automatic logic signed [63:0] sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/mac_neuron_sat.sv
// Combinational clamp of the wide guarded accumulator to the ACC_W output range.
module mac_neuron_sat
    import mac_neuron_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int GUARD_W = DEF_GUARD_W
) (
    input  logic signed [ACC_W+GUARD_W-1:0] acc,
    output logic signed [ACC_W-1:0]         sat
);

    localparam int WIDE_W = ACC_W + GUARD_W;
    localparam logic signed [WIDE_W-1:0] MAX_W = WIDE_W'(sat_max(ACC_W));
    localparam logic signed [WIDE_W-1:0] MIN_W = WIDE_W'(sat_min(ACC_W));

    function automatic logic signed [ACC_W-1:0] clamp(input logic signed [WIDE_W-1:0] v);
        if (v > MAX_W)
            return ACC_W'(MAX_W);
        else if (v < MIN_W)
            return ACC_W'(MIN_W);
        else
            return ACC_W'(v);
    endfunction

    assign sat = clamp(acc);

endmodule

// File: rtl/mac_neuron.sv
// Single-neuron multiply-accumulate: bias + sum(data*weight) over N_INPUTS beats.
// Define MAC_NEURON_SAT_EN to clamp the result instead of wrapping it.
module mac_neuron
    import mac_neuron_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ACC_W    = DEF_ACC_W,
    parameter int N_INPUTS = DEF_N_INPUTS,
    parameter int GUARD_W  = DEF_GUARD_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] in_weight,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_sum,
    output logic                     busy
);

    localparam int WIDE_W = ACC_W + GUARD_W;
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic                     beat_ok;
    logic                     start_ok;
    logic signed [PROD_W-1:0] prod_p1;
    logic                     vld_p1;
    logic signed [WIDE_W-1:0] acc_p2;
    logic signed [WIDE_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0]  sum_fin;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = ACCUM;
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST_CNT)
                    state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign beat_ok   = in_valid && in_ready;
    assign start_ok  = (state == IDLE) && start;

    // Stage 1: operand product register (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (beat_ok)
            prod_p1 <= PROD_W'(in_data) * PROD_W'(in_weight);
    end

    // Stage 2: guarded accumulator; the pending product is folded in every cycle it is valid
    assign acc_nxt = vld_p1 ? acc_p2 + WIDE_W'(prod_p1) : acc_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            cnt     <= '0;
            acc_p2  <= '0;
            out_sum <= '0;
        end else begin
            vld_p1 <= beat_ok;
            if (start_ok) begin
                cnt    <= '0;
                acc_p2 <= WIDE_W'(bias);
            end else begin
                if (beat_ok)
                    cnt <= cnt + 1'b1;
                acc_p2 <= acc_nxt;
            end
            if (state == DRAIN)
                out_sum <= sum_fin;
        end
    end

`ifdef MAC_NEURON_SAT_EN
    mac_neuron_sat #(
        .ACC_W   (ACC_W),
        .GUARD_W (GUARD_W)
    ) u_sat (
        .acc (acc_nxt),
        .sat (sum_fin)
    );
`else
    logic unused_guard;
    assign sum_fin      = acc_nxt[ACC_W-1:0];
    assign unused_guard = ^acc_nxt[WIDE_W-1:ACC_W];
`endif

endmodule

// File: tb/tb_mac_neuron.sv
// Scoreboard bench for mac_neuron with N_INPUTS=4 and directed transactions.
module tb_mac_neuron;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [31:0] bias;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic signed [15:0] in_weight;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_sum;
    logic               busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        held_v = 1'b0;
    logic [31:0] held_sum;

    mac_neuron #(
        .DATA_W   (16),
        .ACC_W    (32),
        .N_INPUTS (N),
        .GUARD_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks hold stability
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (out_valid && held_v)
                chk("out_sum_stable", out_sum, held_sum);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d expected no output", out_sum);
                end else begin
                    chk("out_sum", out_sum, exp_q.pop_front());
                end
                held_v = 1'b0;
            end else begin
                held_v   = out_valid;
                held_sum = out_sum;
            end
        end
    end

    task automatic run_txn(input logic signed [31:0] bias_v, input int d[N], input int w[N],
                           input int gap, input int hold, input bit pulse, input logic [31:0] exp_v);
        out_ready = (hold == 0);
        start     = 1'b1;
        bias      = bias_v;
        exp_q.push_back(exp_v);
        tick();
        start = 1'b0;
        chk("in_ready_after_start", {31'd0, in_ready}, 32'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < N; i++) begin
            in_data   = 16'(d[i]);
            in_weight = 16'(w[i]);
            in_valid  = 1'b1;
            tick();
            in_valid = 1'b0;
            if (i < N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (pulse && g == 0) begin
                        start = 1'b1;
                        bias  = 32'sd1000;
                    end
                    tick();
                    start = 1'b0;
                    chk("in_ready_gap", {31'd0, in_ready}, 32'd1);
                end
            end
        end
        chk("in_ready_drain", {31'd0, in_ready}, 32'd0);
        chk("out_valid_drain", {31'd0, out_valid}, 32'd0);
        tick();
        chk("out_valid_done", {31'd0, out_valid}, 32'd1);
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 0) begin
                start = 1'b1;
                bias  = 32'sd2000;
            end
            tick();
            start = 1'b0;
            chk("out_valid_hold", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("out_valid_dropped", {31'd0, out_valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d[N];
        int w[N];
        logic [31:0] sat_exp;

        rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0;
        in_data = '0; in_weight = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // in_valid alongside start in IDLE must not be taken as a beat
        d = '{1, 2, 3, 4}; w = '{5, 6, 7, 8};
        in_valid = 1'b1; in_data = 16'sd100; in_weight = 16'sd100;
        run_txn(32'sd10, d, w, 0, 0, 1'b0, 32'd80);
        tick();

        d = '{-3, 7, 0, 0}; w = '{4, -2, 9, 9};
        run_txn(32'sd0, d, w, 0, 0, 1'b0, 32'hFFFF_FFE6);
        tick();

        d = '{10, -20, 30, -40}; w = '{3, 3, -2, 1};
        run_txn(-32'sd100, d, w, 2, 5, 1'b0, 32'hFFFF_FF1A);
        tick();

`ifdef MAC_NEURON_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'h7FFB_FFF4;
`endif
        d = '{32767, 32767, 32767, 32767}; w = '{32767, 32767, 32767, 32767};
        run_txn(32'sh7FFF_FFF0, d, w, 0, 0, 1'b0, sat_exp);
        tick();

        // Abort after two beats; nothing from this transaction may reach the output
        out_ready = 1'b1;
        start = 1'b1; bias = 32'sd500;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_data = 16'sd9; in_weight = 16'sd9; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out_sum", out_sum, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        d = '{1, 1, 1, 1}; w = '{1, 1, 1, 1};
        run_txn(32'sd0, d, w, 0, 0, 1'b0, 32'd4);
        tick();

        d = '{1, 1, 1, 1}; w = '{2, 2, 2, 2};
        run_txn(32'sd5, d, w, 1, 3, 1'b1, 32'd13);
        tick();
        tick();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_neuron.md
# mac_neuron

- Single-neuron multiply-accumulate stage: computes bias + Σ(data·weight) over `N_INPUTS` streamed operand pairs.
- Delivers one 32-bit signed sum per transaction through a valid/ready output.
- Sits directly upstream of the ReLU activation; `out_sum` is that block's 32-bit input.

## Interface

Parameters:

- `DATA_W`, 16: width of signed data and weight operands.
- `ACC_W`, 32: output width; must match activation input width.
- `N_INPUTS`, 16: operand pairs per transaction, ≥1.
- `GUARD_W`, 8: extra internal accumulator bits above `ACC_W`.

Ports:

- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin transaction; sampled only in IDLE.
- `bias` input `ACC_W`: signed bias; sampled on accepted `start`.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block accepts operand pair.
- `in_data` input `DATA_W`: signed activation operand.
- `in_weight` input `DATA_W`: signed weight operand.
- `out_valid` output 1: `out_sum` valid.
- `out_ready` input 1: consumer accepts `out_sum`.
- `out_sum` output `ACC_W`: signed result.
- `busy` output 1: high in any state other than IDLE.

## Operation

States:

- IDLE: `in_ready` is 0.
  - On `start`: accumulator ← sign-extended `bias` (width `ACC_W+GUARD_W`), beat counter ← 0, go to ACCUM.
- ACCUM: `in_ready` is 1.
  - A beat is accepted when `in_valid && in_ready`.
  - Each accepted beat: product register ← signed `in_data`·`in_weight` (2·`DATA_W` bits), product-valid flag set, counter increments.
  - Every cycle with product-valid set: accumulator += sign-extended product.
  - When the beat with counter == `N_INPUTS`-1 is accepted, go to DRAIN.
- DRAIN: `in_ready` is 0; the final product is added this cycle; go to DONE.
- DONE: `out_valid` is 1 and `out_sum` is the final result, held stable.
  - On `out_ready`: go to IDLE and drop `out_valid` next cycle.

Rules and boundary conditions:

- `start` while not IDLE: ignored; `bias` not resampled.
- `start` and `in_valid` in the same IDLE cycle: transaction starts; the operand pair is not accepted.
- `in_valid` low in ACCUM: counter and accumulator hold; any pending product still accumulates.
- `out_ready` high before DONE: no effect.
- `N_INPUTS`=1: IDLE→ACCUM→DRAIN→DONE is still followed.
- Reset at any point: transaction aborted and partial accumulator discarded; all outputs return to reset values next cycle.
- Counter width: $clog2(`N_INPUTS`+1).

Reset values:

- `in_ready`=0, `out_valid`=0, `out_sum`=0, `busy`=0.
- State=IDLE; accumulator, counter and product-valid cleared.

## Timing

- `start` accepted in cycle t → `in_ready`=1 from t+1.
- Last beat accepted in cycle t:
  - `in_ready`=0 at t+1 (DRAIN).
  - `out_valid`=1 at t+2.
- Minimum transaction: `N_INPUTS`+3 cycles from `start` to `out_valid`, with back-to-back `in_valid`.
- `out_sum` is registered; it is updated when entering DONE and otherwise holds its last value.
- Next `start` can be accepted one cycle after the `out_valid`/`out_ready` handshake.

## Configuration

Macro `MAC_NEURON_SAT_EN`:

- Defined: the final accumulator is clamped to [-2^(`ACC_W`-1), 2^(`ACC_W`-1)-1] before loading `out_sum`.
- Undefined: `out_sum` = low `ACC_W` bits of the accumulator (two's-complement wrap). The guard bits may then be optimised away.

## Structure

Package `mac_neuron_pkg`:

- State enum: IDLE, ACCUM, DRAIN, DONE.
- Default width constants.
- Saturation bound functions parameterised by `ACC_W`.

Sub-module `mac_neuron_sat`:

- Combinational clamp from `ACC_W+GUARD_W` to `ACC_W`.
- Instantiated only under `MAC_NEURON_SAT_EN`.

## Test plan

- `N_INPUTS`=4, bias=10, data={1,2,3,4}, weights={5,6,7,8}, continuous `in_valid`, `out_ready`=1 → `out_sum`=80; `out_valid` exactly 2 cycles after the 4th beat.
- Signed operands: bias=0, data={-3,7}, weights={4,-2} (`N_INPUTS`=2) → `out_sum`=-26.
- Gapped `in_valid` (beats every 3rd cycle) and `out_ready` held low 5 cycles in DONE → result unchanged; `out_sum` stable while `out_valid` is high; `in_ready`=0 outside ACCUM.
- With `MAC_NEURON_SAT_EN`: bias=0x7FFF_FFF0, data=weight=32767 → `out_sum`=0x7FFF_FFFF. Without the macro → wrapped low 32 bits of the exact sum.
- `rst` asserted after 2 of 4 beats, then a new transaction with bias=0, all data=1, all weights=1 → `out_sum`=4; no residue from the aborted transaction.
- `start` pulsed during ACCUM and DONE with a different bias → ignored; result uses the original bias.
